axi_write_arbiter: RTL and testbench
====================================

Name: axi_write_arbiter

Overview:
Shares one AXI4-Lite write slave (AW/W/B channels) between NUM_MASTERS requesting masters.
Grants one master at a time and routes its AW and W channels to the slave. Holds the grant until the slave's B response has been handshaken back to that master.
Sits between the master-side write engines and the single slave write port.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
ACLK  input  1  clock
ARESET  input  1  reset, asynchronous, active-low
S_AWADDR  input  NUM_MASTERS*ADDR_W  per-master write address; master i at slice [i*ADDR_W +: ADDR_W]
S_AWVALID  input  NUM_MASTERS  per-master address valid
S_AWREADY  output  NUM_MASTERS  per-master address ready
S_WDATA  input  NUM_MASTERS*DATA_W  per-master write data
S_WSTRB  input  NUM_MASTERS*DATA_W/8  per-master byte strobes
S_WVALID  input  NUM_MASTERS  per-master data valid
S_WREADY  output  NUM_MASTERS  per-master data ready
S_BRESP  output  NUM_MASTERS*2  per-master response code
S_BVALID  output  NUM_MASTERS  per-master response valid
S_BREADY  input  NUM_MASTERS  per-master response ready
M_AWADDR/M_AWVALID  output  ADDR_W/1  to slave
M_AWREADY  input  1  from slave
M_WDATA/M_WSTRB/M_WVALID  output  DATA_W/DATA_W/8/1  to slave
M_WREADY  input  1  from slave
M_BRESP  input  2  from slave
M_BVALID  input  1  from slave
M_BREADY  output  1  to slave

Behaviour:
- Reset is asynchronous, active-low on ARESET; clock is ACLK.
- Reset values:
  - state = IDLE; grant index = 0; rr pointer = 0; aw_done = w_done = 0.
  - All S_*READY, S_BVALID, M_AWVALID, M_WVALID and M_BREADY are 0.
  - M_AWADDR, M_WDATA, M_WSTRB and S_BRESP are 0.
- Request: master i is requesting when S_AWVALID[i] = 1.
- FSM states: IDLE -> GRANT -> RESP -> IDLE.
- IDLE:
  - If any request is present, select a winner round-robin, starting at the rr pointer.
  - Register the winner as the grant index and go to GRANT on the next edge.
  - Arbitration latency is 1 cycle. No master sees READY in IDLE.
- GRANT, with g = grant index:
  - M_AWADDR = S_AWADDR[g]; M_AWVALID = S_AWVALID[g] & ~aw_done; S_AWREADY[g] = M_AWREADY & ~aw_done.
  - The W channel is forwarded the same way using w_done.
  - Each done flag sets on its channel's handshake. AW and W may complete in either order or in the same cycle.
  - When both are done (including the completing cycle), go to RESP and clear both flags.
  - Non-granted masters see READY = 0.
- RESP:
  - S_BVALID[g] = M_BVALID; S_BRESP[g] = M_BRESP; M_BREADY = S_BREADY[g].
  - On the B handshake: go to IDLE and set rr pointer = (g+1) mod NUM_MASTERS.
- Forwarding is combinational from registered state (no added pipeline delay).
- When not routed, all data/address/resp outputs are driven to 0.
- M_BVALID outside RESP is ignored (M_BREADY = 0).
- A granted master that drops AWVALID before the handshake breaks the AXI protocol. The arbiter stays in GRANT and does not re-arbitrate.
- ARESET asserted mid-transfer returns the block to reset values at once. An in-flight slave response is not forwarded.
- Back-to-back: the earliest next grant is the cycle after the B handshake plus 1 cycle of IDLE arbitration.

Optional Feature:
- Macro: AXI_WARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest index wins; the rr pointer is unused and stays 0.
- Undefined (default): round-robin as described above.

Decomposition:
- Package axi_pkg holds:
  - AXI_RESP_OKAY = 2'b00, AXI_RESP_SLVERR = 2'b10.
  - Arbiter state encoding: IDLE = 2'b00, GRANT = 2'b01, RESP = 2'b10.
  - A clog2-based grant index width helper.
- Sub-module rr_arbiter: combinational request vector + pointer -> one-hot grant and index. The fixed-priority option is selected inside it.

Test Plan:
- Single request: S_AWVALID[0] = 1 with addr 0x4, data 0xA5A5A5A5, strb 0xF; slave ready immediately.
  -> M_AWVALID rises 1 cycle after the request; B OKAY is returned on S_BVALID[0]; S_*READY[1] stays 0 throughout.
- Simultaneous requests from masters 0 and 1, repeated 4 times.
  -> Grants go 0,1,0,1. With AXI_WARB_FIXED_PRIO_EN defined, grants go 0,0,0,0 while master 0 keeps requesting.
- Channel ordering: slave asserts M_WREADY 3 cycles before M_AWREADY.
  -> W handshake happens exactly once; RESP is entered only after AW completes; no duplicate M_WVALID after w_done.
- Response backpressure: M_BVALID = 1 with BRESP = 2'b10 while S_BREADY[1] = 0 for 5 cycles.
  -> M_BREADY is held 0; S_BRESP[1] = 2'b10 stays stable; no new grant until the handshake.
- Reset during GRANT after the AW handshake but before W.
  -> All VALID/READY outputs are 0 in the same cycle; state is IDLE; after release, the rr pointer is 0.
- Stray M_BVALID in IDLE.
  -> M_BREADY = 0 and no S_BVALID is asserted.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI4-Lite write arbiter definitions: response codes, FSM encoding, index width helper.
package axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    RESP  = 2'b10
  } arb_state_t;

  // A single master still needs a 1-bit index to keep vectors legal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational requester pick: round-robin from ptr, or lowest index when
// AXI_WARB_FIXED_PRIO_EN is defined.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any_req
);

  logic [IW-1:0] cand;

`ifdef AXI_WARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Walk from the top down so the lowest requesting index is the last writer.
  always_comb begin
    gnt     = '0;
    idx     = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = IW'(i);
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        idx       = cand;
        any_req   = 1'b1;
      end
    end
  end
`else
  always_comb begin
    gnt     = '0;
    idx     = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!any_req && req[cand]) begin
        any_req   = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/axi_write_arbiter.sv
// Shares one AXI4-Lite write slave among NUM_MASTERS masters; a grant is held from AW/W until B returns.
// Define AXI_WARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module axi_write_arbiter
  import axi_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   S_AWADDR,
  input  logic [NUM_MASTERS-1:0]          S_AWVALID,
  output logic [NUM_MASTERS-1:0]          S_AWREADY,
  input  logic [NUM_MASTERS*DATA_W-1:0]   S_WDATA,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] S_WSTRB,
  input  logic [NUM_MASTERS-1:0]          S_WVALID,
  output logic [NUM_MASTERS-1:0]          S_WREADY,
  output logic [NUM_MASTERS*2-1:0]        S_BRESP,
  output logic [NUM_MASTERS-1:0]          S_BVALID,
  input  logic [NUM_MASTERS-1:0]          S_BREADY,
  output logic [ADDR_W-1:0]               M_AWADDR,
  output logic                            M_AWVALID,
  input  logic                            M_AWREADY,
  output logic [DATA_W-1:0]               M_WDATA,
  output logic [DATA_W/8-1:0]             M_WSTRB,
  output logic                            M_WVALID,
  input  logic                            M_WREADY,
  input  logic [1:0]                      M_BRESP,
  input  logic                            M_BVALID,
  output logic                            M_BREADY
);

  localparam int IW = idx_w(NUM_MASTERS);
  localparam int SW = DATA_W / 8;

  arb_state_t             state, state_n;
  logic [IW-1:0]          grant_idx, grant_n, rr_ptr, ptr_n, win_idx;
  logic                   aw_done, aw_done_n, w_done, w_done_n;
  logic                   any_req, aw_hs, w_hs;
  logic [NUM_MASTERS-1:0] unused_win_gnt;

  logic [ADDR_W-1:0] aw_addr [NUM_MASTERS];
  logic [DATA_W-1:0] w_data  [NUM_MASTERS];
  logic [SW-1:0]     w_strb  [NUM_MASTERS];

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign aw_addr[i] = S_AWADDR[i*ADDR_W +: ADDR_W];
    assign w_data[i]  = S_WDATA[i*DATA_W +: DATA_W];
    assign w_strb[i]  = S_WSTRB[i*SW +: SW];
  end

  rr_arbiter #(.N(NUM_MASTERS), .IW(IW)) u_arb (
    .req     (S_AWVALID),
    .ptr     (rr_ptr),
    .gnt     (unused_win_gnt),
    .idx     (win_idx),
    .any_req (any_req)
  );

  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      state     <= IDLE;
      grant_idx <= '0;
      rr_ptr    <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      state     <= state_n;
      grant_idx <= grant_n;
      rr_ptr    <= ptr_n;
      aw_done   <= aw_done_n;
      w_done    <= w_done_n;
    end
  end

  always_comb begin
    state_n   = state;
    grant_n   = grant_idx;
    ptr_n     = rr_ptr;
    aw_done_n = aw_done;
    w_done_n  = w_done;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    S_AWREADY = '0;
    S_WREADY  = '0;
    S_BVALID  = '0;
    S_BRESP   = {NUM_MASTERS{AXI_RESP_OKAY}};
    M_AWADDR  = '0;
    M_AWVALID = 1'b0;
    M_WDATA   = '0;
    M_WSTRB   = '0;
    M_WVALID  = 1'b0;
    M_BREADY  = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          grant_n = win_idx;
          state_n = GRANT;
        end
      end
      GRANT: begin
        M_AWADDR  = aw_addr[grant_idx];
        M_AWVALID = S_AWVALID[grant_idx] & ~aw_done;
        M_WDATA   = w_data[grant_idx];
        M_WSTRB   = w_strb[grant_idx];
        M_WVALID  = S_WVALID[grant_idx] & ~w_done;
        for (int i = 0; i < NUM_MASTERS; i++) begin
          if (grant_idx == IW'(i)) begin
            S_AWREADY[i] = M_AWREADY & ~aw_done;
            S_WREADY[i]  = M_WREADY & ~w_done;
          end
        end
        aw_hs = M_AWVALID & M_AWREADY;
        w_hs  = M_WVALID & M_WREADY;
        // The completing handshake counts, so AW and W may finish in either order or together.
        if ((aw_done | aw_hs) && (w_done | w_hs)) begin
          state_n   = RESP;
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
        end else begin
          aw_done_n = aw_done | aw_hs;
          w_done_n  = w_done | w_hs;
        end
      end
      RESP: begin
        M_BREADY = S_BREADY[grant_idx];
        for (int i = 0; i < NUM_MASTERS; i++) begin
          if (grant_idx == IW'(i)) begin
            S_BVALID[i]      = M_BVALID;
            S_BRESP[i*2 +: 2] = M_BRESP;
          end
        end
        if (M_BVALID && M_BREADY) begin
          state_n = IDLE;
`ifdef AXI_WARB_FIXED_PRIO_EN
          ptr_n = rr_ptr;
`else
          ptr_n = (grant_idx == IW'(NUM_MASTERS - 1)) ? '0 : grant_idx + 1'b1;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Bench for axi_write_arbiter: scoreboard of expected write transactions in grant order,
// checked at the slave-side AW/W handshakes and at each master's B handshake.
module tb_axi_write_arbiter;
  import axi_pkg::*;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic             ACLK = 1'b0;
  logic             ARESET = 1'b0;
  logic [NM*AW-1:0] S_AWADDR;
  logic [NM-1:0]    S_AWVALID, S_AWREADY;
  logic [NM*DW-1:0] S_WDATA;
  logic [NM*SW-1:0] S_WSTRB;
  logic [NM-1:0]    S_WVALID, S_WREADY;
  logic [NM*2-1:0]  S_BRESP;
  logic [NM-1:0]    S_BVALID, S_BREADY;
  logic [AW-1:0]    M_AWADDR;
  logic             M_AWVALID, M_AWREADY;
  logic [DW-1:0]    M_WDATA;
  logic [SW-1:0]    M_WSTRB;
  logic             M_WVALID, M_WREADY;
  logic [1:0]       M_BRESP;
  logic             M_BVALID, M_BREADY;

  always #5 ACLK = ~ACLK;

  axi_write_arbiter #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY)
  );

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
  } exp_t;

  exp_t          exp_q[$];
  int            errors = 0;
  int            checks = 0;
  logic [NM-1:0] aw_pend, w_pend, bready_en, s_aw_hs, s_w_hs, s_b_hs;
  logic          aw_hs, w_hs, b_hs, got_aw, got_w, m1_touch;
  logic [1:0]    slave_resp;
  int            cnt[NM];
  int            rep[NM];
  int            w_cnt;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] gen_addr(input int m, input int k);
    return 32'(32'h1000 * (m + 1) + k * 4);
  endfunction

  function automatic logic [31:0] gen_data(input int m, input int k);
    return 32'hC0DE_0000 | 32'(m << 8) | 32'(k);
  endfunction

  function automatic logic [3:0] gen_strb(input int k);
    return 4'(k + 1);
  endfunction

  task automatic drive();
    S_AWVALID = aw_pend;
    S_WVALID  = w_pend;
    S_BREADY  = bready_en;
  endtask

  task automatic push_exp(input int m, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] r);
    exp_t e;
    e.m = m; e.addr = a; e.data = d; e.strb = s; e.resp = r;
    exp_q.push_back(e);
  endtask

  task automatic push_k(input int m, input int k);
    push_exp(m, gen_addr(m, k), gen_data(m, k), gen_strb(k), AXI_RESP_OKAY);
  endtask

  task automatic issue(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    S_AWADDR[m*AW +: AW] = a;
    S_WDATA[m*DW +: DW]  = d;
    S_WSTRB[m*SW +: SW]  = s;
    aw_pend[m] = 1'b1;
    w_pend[m]  = 1'b1;
    drive();
  endtask

  task automatic issue_k(input int m);
    issue(m, gen_addr(m, cnt[m]), gen_data(m, cnt[m]), gen_strb(cnt[m]));
    cnt[m]++;
  endtask

  // Sample at the falling edge, react just after the rising edge.
  task automatic cycle();
    @(negedge ACLK);
    aw_hs   = M_AWVALID & M_AWREADY;
    w_hs    = M_WVALID & M_WREADY;
    b_hs    = M_BVALID & M_BREADY;
    s_aw_hs = S_AWVALID & S_AWREADY;
    s_w_hs  = S_WVALID & S_WREADY;
    s_b_hs  = S_BVALID & S_BREADY;
    m1_touch = m1_touch | S_AWREADY[1] | S_WREADY[1] | S_BVALID[1];
    if (w_hs) w_cnt++;
    if (aw_hs) begin
      chk("aw_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        chk("aw_grant", S_AWREADY, NM'(1) << exp_q[0].m);
        chk("aw_addr", M_AWADDR, exp_q[0].addr);
      end
    end
    if (w_hs) begin
      chk("w_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        chk("w_grant", S_WREADY, NM'(1) << exp_q[0].m);
        chk("w_data", {M_WDATA, M_WSTRB}, {exp_q[0].data, exp_q[0].strb});
      end
    end
    for (int m = 0; m < NM; m++) begin
      if (s_b_hs[m]) begin
        chk("b_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          chk("b_master", m, exp_q[0].m);
          chk("b_resp", S_BRESP[m*2 +: 2], exp_q[0].resp);
          void'(exp_q.pop_front());
        end
      end
    end
    @(posedge ACLK);
    #1;
    for (int m = 0; m < NM; m++) begin
      if (s_aw_hs[m]) aw_pend[m] = 1'b0;
      if (s_w_hs[m])  w_pend[m]  = 1'b0;
    end
    if (aw_hs) got_aw = 1'b1;
    if (w_hs)  got_w  = 1'b1;
    if (b_hs)  M_BVALID = 1'b0;
    if (got_aw && got_w) begin
      M_BVALID = 1'b1;
      M_BRESP  = slave_resp;
      got_aw   = 1'b0;
      got_w    = 1'b0;
    end
    for (int m = 0; m < NM; m++) begin
      if (s_b_hs[m] && rep[m] > 0) begin
        rep[m]--;
        issue_k(m);
      end
    end
    drive();
    #1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || M_BVALID || aw_pend != 0 || w_pend != 0) && n < budget) begin
      cycle();
      n++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    S_AWADDR = '0; S_WDATA = '0; S_WSTRB = '0;
    M_AWREADY = 1'b1; M_WREADY = 1'b1; M_BVALID = 1'b0; M_BRESP = 2'b00;
    aw_pend = '0; w_pend = '0; bready_en = '1;
    got_aw = 1'b0; got_w = 1'b0; slave_resp = AXI_RESP_OKAY;
    m1_touch = 1'b0; w_cnt = 0;
    for (int m = 0; m < NM; m++) begin cnt[m] = 0; rep[m] = 0; end
    drive();

    // Reset state
    repeat (2) @(posedge ACLK);
    #1;
    chk("rst_vld_rdy", {S_AWREADY, S_WREADY, S_BVALID, M_AWVALID, M_WVALID, M_BREADY}, 0);
    chk("rst_data", {M_AWADDR, M_WDATA, M_WSTRB, S_BRESP}, 0);
    chk("rst_state", dut.state, IDLE);
    chk("rst_regs", {dut.grant_idx, dut.rr_ptr, dut.aw_done, dut.w_done}, 0);
    ARESET = 1'b1;

    // Single request from master 0, slave ready at once
    push_exp(0, 32'h4, 32'hA5A5A5A5, 4'hF, AXI_RESP_OKAY);
    issue(0, 32'h4, 32'hA5A5A5A5, 4'hF);
    #1;
    chk("t1_aw_idle", M_AWVALID, 0);
    cycle();
    chk("t1_aw_rise", M_AWVALID, 1);
    chk("t1_aw_addr", M_AWADDR, 32'h4);
    wait_done("t1_done", 40);
    chk("t1_m1_quiet", m1_touch, 0);

    // Response backpressure on master 1 with SLVERR, master 0 waiting
    slave_resp = AXI_RESP_SLVERR;
    bready_en[1] = 1'b0;
    push_exp(1, 32'h80, 32'h1234_5678, 4'h3, AXI_RESP_SLVERR);
    issue(1, 32'h80, 32'h1234_5678, 4'h3);
    cycle();
    cycle();
    push_exp(0, 32'h90, 32'h0BAD_F00D, 4'hC, AXI_RESP_SLVERR);
    issue(0, 32'h90, 32'h0BAD_F00D, 4'hC);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t4_bready_low", M_BREADY, 0);
      chk("t4_bresp_hold", {S_BVALID[1], S_BRESP[3:2]}, 3'b110);
      chk("t4_no_regrant", {S_AWREADY[0], dut.state}, {1'b0, RESP});
    end
    bready_en[1] = 1'b1;
    drive();
    wait_done("t4_done", 40);
    slave_resp = AXI_RESP_OKAY;

    // W ready three cycles ahead of AW ready
    M_AWREADY = 1'b0;
    w_cnt = 0;
    push_exp(0, 32'hA0, 32'h5555_AAAA, 4'h9, AXI_RESP_OKAY);
    issue(0, 32'hA0, 32'h5555_AAAA, 4'h9);
    cycle();
    repeat (3) cycle();
    chk("t3_still_grant", dut.state, GRANT);
    chk("t3_no_dup_w", {M_WVALID, M_AWVALID}, 2'b01);
    M_AWREADY = 1'b1;
    wait_done("t3_done", 40);
    chk("t3_w_once", w_cnt, 1);

    // Reset after AW handshake, before W
    M_WREADY = 1'b0;
    push_exp(1, 32'hB0, 32'hDEAD_BEEF, 4'hF, AXI_RESP_OKAY);
    issue(1, 32'hB0, 32'hDEAD_BEEF, 4'hF);
    cycle();
    cycle();
    chk("t5_aw_done", {dut.state, dut.aw_done, dut.w_done}, {GRANT, 2'b10});
    ARESET = 1'b0;
    M_BVALID = 1'b1;
    #1;
    chk("t5_rst_vld_rdy", {S_AWREADY, S_WREADY, S_BVALID, M_AWVALID, M_WVALID, M_BREADY}, 0);
    chk("t5_rst_state", dut.state, IDLE);
    exp_q.delete();
    got_aw = 1'b0; got_w = 1'b0;
    aw_pend = '0; w_pend = '0;
    drive();
    M_BVALID = 1'b0;
    M_WREADY = 1'b1;
    repeat (2) cycle();
    ARESET = 1'b1;
    #1;
    chk("t5_ptr_after", {dut.rr_ptr, dut.grant_idx}, 0);

    // Simultaneous requests, master 0 re-requesting immediately
`ifdef AXI_WARB_FIXED_PRIO_EN
    for (int k = 0; k < 4; k++) push_k(0, k);
    push_k(1, 0);
    rep[0] = 3; rep[1] = 0;
`else
    for (int k = 0; k < 2; k++) begin
      push_k(0, k);
      push_k(1, k);
    end
    rep[0] = 1; rep[1] = 1;
`endif
    issue_k(0);
    issue_k(1);
    wait_done("t2_done", 200);
    chk("t2_ptr_end", dut.rr_ptr, 0);

    // Stray slave response while idle
    M_BVALID = 1'b1;
    M_BRESP = AXI_RESP_SLVERR;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t6_bready_low", {M_BREADY, S_BVALID}, 0);
      chk("t6_idle", dut.state, IDLE);
      chk("t6_outputs_zero", {M_AWADDR, M_WDATA, M_WSTRB, S_BRESP}, 0);
    end
    M_BVALID = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
